// File: rtl/accumulator_sequencer_if.sv
// accumulator_sequencer_if: command handshake from decode plus the
// accumulator drive/echo bus. The slave modport is the sequencer's view;
// the master modport is the decode/accumulator environment's view.
interface accumulator_sequencer_if #(
  parameter int unsigned CTR_W = 12
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_op;
  logic [7:0]       cmd_value;
  logic [1:0]       cmd_nargs;
  logic [CTR_W-1:0] accumulator_ctr;
  logic             putEn;
  logic             opEn;
  logic [7:0]       value;
  logic [CTR_W-1:0] control_ctr;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_value,
    output cmd_nargs,
    output accumulator_ctr,
    input  cmd_ready,
    input  putEn,
    input  opEn,
    input  value,
    input  control_ctr
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_value,
    input  cmd_nargs,
    input  accumulator_ctr,
    output cmd_ready,
    output putEn,
    output opEn,
    output value,
    output control_ctr
  );
endinterface

// File: rtl/accumulator_sequencer.sv
// accumulator_sequencer: sequences put/op commands into the three-slot
// operand accumulator, tags every issued command and tracks slot occupancy.
// Optional feature macro: ACC_SEQ_ECHO_CHECK_EN -- when defined, each issued
// command waits for the accumulator_ctr echo (with timeout) before the next
// command is accepted; when undefined, ISSUE returns straight to IDLE.
module accumulator_sequencer #(
  parameter int unsigned CTR_W        = 12,
  parameter int unsigned ECHO_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  accumulator_sequencer_if.slave bus,
  input  logic                   err_clr,
  output logic [1:0]             fill_count,
  output logic                   op_fire,
  output logic                   busy,
  output logic                   err_overflow,
  output logic                   err_underflow,
  output logic                   err_timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t state;

  logic accept;
  logic ovf_hit;
  logic unf_hit;
  logic issue_go;

  // Command acceptance and legality check against current occupancy
  always_comb begin
    accept   = (state == S_IDLE) && bus.cmd_valid;
    ovf_hit  = accept && !bus.cmd_op && (fill_count == 2'd3);
    unf_hit  = accept && bus.cmd_op && (bus.cmd_nargs > fill_count);
    issue_go = accept && !ovf_hit && !unf_hit;
  end

`ifdef ACC_SEQ_ECHO_CHECK_EN
  localparam int unsigned WCNT_W = $clog2(ECHO_TIMEOUT + 1);

  logic [WCNT_W-1:0] wait_cnt;
  logic              echo_hit;
  logic              tmo_hit;

  // Echo match and timeout detection while waiting
  always_comb begin
    echo_hit = (state == S_WAIT) && (bus.accumulator_ctr == bus.control_ctr);
    tmo_hit  = (state == S_WAIT) && !echo_hit &&
               (wait_cnt == WCNT_W'(ECHO_TIMEOUT - 1));
  end

  // Wait counter (zero outside WAIT, so it is clear on entry) and sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= tmo_hit | (err_timeout & ~err_clr);
      if ((state == S_WAIT) && !echo_hit && !tmo_hit) begin
        wait_cnt <= wait_cnt + WCNT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
    end
  end
`else
  localparam int unsigned unused_echo_timeout = ECHO_TIMEOUT;

  logic unused_echo;

  // Echo is ignored without the echo check; timeout can never occur
  assign unused_echo = ^bus.accumulator_ctr;
  assign err_timeout = 1'b0;
`endif

  // Sequencer FSM with registered strobes, tag, occupancy and error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      bus.cmd_ready   <= 1'b1;
      busy            <= 1'b0;
      bus.putEn       <= 1'b0;
      bus.opEn        <= 1'b0;
      op_fire         <= 1'b0;
      bus.value       <= 8'd0;
      bus.control_ctr <= '0;
      fill_count      <= 2'd0;
      err_overflow    <= 1'b0;
      err_underflow   <= 1'b0;
    end else begin
      // set wins over a simultaneous clear
      err_overflow  <= ovf_hit | (err_overflow & ~err_clr);
      err_underflow <= unf_hit | (err_underflow & ~err_clr);
      op_fire       <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (issue_go) begin
            state           <= S_ISSUE;
            bus.cmd_ready   <= 1'b0;
            busy            <= 1'b1;
            bus.putEn       <= ~bus.cmd_op;
            bus.opEn        <= bus.cmd_op;
            op_fire         <= bus.cmd_op;
            bus.control_ctr <= bus.control_ctr + CTR_W'(1);
            if (bus.cmd_op) begin
              fill_count <= 2'd0;
            end else begin
              bus.value  <= bus.cmd_value;
              fill_count <= fill_count + 2'd1;
            end
          end
        end

        S_ISSUE: begin
`ifdef ACC_SEQ_ECHO_CHECK_EN
          state <= S_WAIT;
`else
          state         <= S_IDLE;
          bus.cmd_ready <= 1'b1;
          busy          <= 1'b0;
          bus.putEn     <= 1'b0;
          bus.opEn      <= 1'b0;
`endif
        end

`ifdef ACC_SEQ_ECHO_CHECK_EN
        S_WAIT: begin
          if (echo_hit || tmo_hit) begin
            state         <= S_IDLE;
            bus.cmd_ready <= 1'b1;
            busy          <= 1'b0;
            bus.putEn     <= 1'b0;
            bus.opEn      <= 1'b0;
          end
        end
`endif

        default: begin
          state         <= S_IDLE;
          bus.cmd_ready <= 1'b1;
          busy          <= 1'b0;
          bus.putEn     <= 1'b0;
          bus.opEn      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accumulator_sequencer.sv
// tb_accumulator_sequencer: directed and randomized command streams checked
// against a transaction-level model of occupancy, tags, values and errors.
module tb_accumulator_sequencer;

  localparam int unsigned CTR_W = 12;
  localparam int unsigned TMO   = 15;
  localparam int          NTAGS = 4096;

  logic       clk;
  logic       reset;
  logic       err_clr;
  logic [1:0] fill_count;
  logic       op_fire;
  logic       busy;
  logic       err_overflow;
  logic       err_underflow;
  logic       err_timeout;

  accumulator_sequencer_if #(.CTR_W(CTR_W)) ifc ();

  accumulator_sequencer #(
    .CTR_W        (CTR_W),
    .ECHO_TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (ifc),
    .err_clr       (err_clr),
    .fill_count    (fill_count),
    .op_fire       (op_fire),
    .busy          (busy),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .err_timeout   (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // accumulator echo model: live echo returns the tag, stale echo holds an old tag
  logic             echo_live;
  logic [CTR_W-1:0] echo_stale;
  always_comb ifc.accumulator_ctr = echo_live ? ifc.control_ctr : echo_stale;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_fill;
  int m_tag;
  int m_val;
  bit m_ovf;
  bit m_unf;
  bit m_tmo;
  int n_issued;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_ovf"}, err_overflow, m_ovf);
    check({tag, "_unf"}, err_underflow, m_unf);
    check({tag, "_tmo"}, err_timeout, m_tmo);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, ifc.cmd_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_put"}, ifc.putEn, 0);
    check({tag, "_opEn"}, ifc.opEn, 0);
    check({tag, "_fire"}, op_fire, 0);
    check({tag, "_fill"}, fill_count, m_fill);
    check({tag, "_ctr"}, ifc.control_ctr, m_tag);
    check({tag, "_val"}, ifc.value, m_val);
    check_flags(tag);
  endtask

  task automatic model_reset();
    m_fill = 0; m_tag = 0; m_val = 0;
    m_ovf = 0; m_unf = 0; m_tmo = 0;
  endtask

  // one command end to end; starts and ends on a negedge with the DUT idle
  task automatic do_cmd(input bit op, input logic [7:0] v, input logic [1:0] n,
                        input bit clr, input bit stale);
    int  guard;
    bit  rej_o;
    bit  rej_u;
    guard = 0;
    while (ifc.cmd_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", guard < 100, 1);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = op;
    ifc.cmd_value = v;
    ifc.cmd_nargs = n;
    err_clr       = clr;
    echo_live     = !stale;
    echo_stale    = CTR_W'(m_tag);
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    err_clr       = 1'b0;

    if (clr) begin
      m_ovf = 0; m_unf = 0; m_tmo = 0;
    end
    rej_o = !op && (m_fill == 3);
    rej_u = op && (int'(n) > m_fill);
    if (rej_o) m_ovf = 1;
    if (rej_u) m_unf = 1;
    if (rej_o || rej_u) begin
      check_idle("reject");
      return;
    end

    m_tag = (m_tag + 1) % NTAGS;
    if (op) m_fill = 0;
    else begin
      m_fill++;
      m_val = int'(v);
    end
    n_issued++;

    check("iss_put", ifc.putEn, !op);
    check("iss_opEn", ifc.opEn, op);
    check("iss_fire", op_fire, op);
    check("iss_val", ifc.value, m_val);
    check("iss_ctr", ifc.control_ctr, m_tag);
    check("iss_fill", fill_count, m_fill);
    check("iss_busy", busy, 1);
    check("iss_ready", ifc.cmd_ready, 0);
    check_flags("iss");

`ifdef ACC_SEQ_ECHO_CHECK_EN
    @(negedge clk);
    check("wait_put", ifc.putEn, !op);
    check("wait_opEn", ifc.opEn, op);
    check("wait_fire", op_fire, 0);
    check("wait_val", ifc.value, m_val);
    check("wait_ctr", ifc.control_ctr, m_tag);
    check("wait_busy", busy, 1);
    if (stale) begin
      repeat (TMO - 1) @(negedge clk);
      check("tmo_early_busy", busy, 1);
      check("tmo_early_flag", err_timeout, m_tmo);
      @(negedge clk);
      m_tmo = 1;
    end else begin
      @(negedge clk);
    end
`else
    @(negedge clk);
`endif
    check_idle("done");
    echo_live = 1'b1;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_ovf = 0; m_unf = 0; m_tmo = 0;
    check_flags("clr");
  endtask

  task automatic reset_mid();
    if (m_fill == 3) do_cmd(1'b1, 8'd0, 2'd0, 1'b0, 1'b0);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = 1'b0;
    ifc.cmd_value = 8'hA5;
    ifc.cmd_nargs = 2'd0;
    echo_live     = 1'b0;
    echo_stale    = CTR_W'(m_tag);
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    check("rmid_issue_put", ifc.putEn, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    check_idle("rmid");
    reset = 1'b0;
    echo_live = 1'b1;
    @(negedge clk);
    check_idle("rmid_after");
  endtask

  initial begin
    int iter;
    reset         = 1'b1;
    err_clr       = 1'b0;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = 1'b0;
    ifc.cmd_value = 8'd0;
    ifc.cmd_nargs = 2'd0;
    echo_live     = 1'b1;
    echo_stale    = '0;
    n_issued      = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clk);

    // three puts and an op
    do_cmd(1'b0, 8'd5, 2'd0, 1'b0, 1'b0);
    do_cmd(1'b0, 8'd9, 2'd0, 1'b0, 1'b0);
    do_cmd(1'b0, 8'd12, 2'd0, 1'b0, 1'b0);
    check("seq_tag3", ifc.control_ctr, 3);
    do_cmd(1'b1, 8'd0, 2'd3, 1'b0, 1'b0);
    check("seq_tag4", ifc.control_ctr, 4);
    check("seq_val12", ifc.value, 12);

    // overflow then clear
    do_cmd(1'b0, 8'd1, 2'd0, 1'b0, 1'b0);
    do_cmd(1'b0, 8'd2, 2'd0, 1'b0, 1'b0);
    do_cmd(1'b0, 8'd3, 2'd0, 1'b0, 1'b0);
    do_cmd(1'b0, 8'd7, 2'd0, 1'b0, 1'b0);
    check("ovf_flag", err_overflow, 1);
    clear_errs();

    // underflow
    do_cmd(1'b1, 8'd0, 2'd0, 1'b0, 1'b0);
    do_cmd(1'b0, 8'd33, 2'd0, 1'b0, 1'b0);
    do_cmd(1'b1, 8'd0, 2'd2, 1'b0, 1'b0);
    check("unf_flag", err_underflow, 1);
    check("unf_fill", fill_count, 1);

    // stale echo (times out when echo checking is built in), then next put
    do_cmd(1'b0, 8'd44, 2'd0, 1'b0, 1'b1);
    do_cmd(1'b0, 8'd45, 2'd0, 1'b0, 1'b0);

    // clear and a new error in the same cycle: set wins
    do_cmd(1'b1, 8'd0, 2'd0, 1'b0, 1'b0);
    do_cmd(1'b1, 8'd0, 2'd1, 1'b1, 1'b0);
    check("setwins_unf", err_underflow, 1);

    reset_mid();

    // randomized stream long enough to wrap the tag
    iter = 0;
    while (n_issued < NTAGS + 40 && iter < 9000) begin
      do_cmd(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
             2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 127) == 0));
      iter++;
    end
    check("wrap_reached", n_issued >= NTAGS + 40, 1);

    reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accumulator_sequencer.md
# accumulator_sequencer

- Sequences the three-slot operand accumulator.
- Accepts a valid/ready command stream (put operand / fire op) from the decode stage and tracks slot occupancy.
- Drives the accumulator's `putEn`, `opEn`, `value` and `control_ctr` inputs, incrementing the tag once per issued command.
- Optionally waits for the accumulator's `accumulator_ctr` echo before accepting the next command, and flags overflow, underflow and timeout errors.

## Interface
Parameters:
- `CTR_W`, 12: width of `control_ctr` / `accumulator_ctr`.
- `ECHO_TIMEOUT`, 15: max WAIT cycles before `err_timeout` (≥1).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: sequencer accepts command this cycle.
- `cmd_op` in 1: 0 = put `cmd_value`, 1 = fire op.
- `cmd_value` in 8: operand for put.
- `cmd_nargs` in 2: operands an op requires (0–3).
- `err_clr` in 1: clears sticky error flags.
- `accumulator_ctr` in CTR_W: echo from accumulator.
- `putEn` out 1: accumulator put strobe.
- `opEn` out 1: accumulator op strobe.
- `value` out 8: operand to accumulator.
- `control_ctr` out CTR_W: command tag.
- `fill_count` out 2: occupied slots (0–3).
- `op_fire` out 1: one-cycle pulse when an op issues.
- `busy` out 1: state ≠ IDLE.
- `err_overflow`, `err_underflow`, `err_timeout` out 1 each: sticky error flags.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`, the command is captured and checked:
    - Put with `fill_count`=3: consumed, not issued, `err_overflow` set, stay IDLE.
    - Op with `cmd_nargs` > `fill_count`: consumed, not issued, `err_underflow` set, stay IDLE.
    - Otherwise go to ISSUE and increment `control_ctr` (mod 2^CTR_W).
- **ISSUE** (exactly one cycle)
  - Put: `putEn`=1, `opEn`=0, `value`=captured operand, `fill_count`+1.
  - Op: `opEn`=1, `putEn`=0, `value` holds its previous value, `fill_count`←0, `op_fire`=1.
  - Next state is WAIT.
- **WAIT**
  - Strobes and `value` held.
  - If `accumulator_ctr`==`control_ctr`: go IDLE.
  - Else increment the wait counter; when it reaches `ECHO_TIMEOUT`, set `err_timeout` and go IDLE.
- **Outside ISSUE/WAIT:** `putEn`=`opEn`=0; `control_ctr` and `value` held.
- **Wrap-around:** `control_ctr` wraps 2^CTR_W−1 → 0; each issue still differs from the previous tag.
- **Error flags:**
  - Sticky; cleared only by `err_clr` or `reset`.
  - If `err_clr` and a new error occur in the same cycle, the set wins.
- **Reset mid-operation:** from any state, returns to IDLE next edge and all outputs take reset values; an in-flight command is dropped.

## Timing
Reset values:
- `cmd_ready`=1 (IDLE).
- `putEn`, `opEn`, `op_fire`, `busy` = 0.
- `value`=0, `control_ctr`=0, `fill_count`=0.
- All error flags = 0.
- Wait counter = 0.

Command cycle:
- Accept at edge T.
- Strobes and new `control_ctr` are visible T+1 (ISSUE) through the last WAIT cycle.
- With an immediate (combinational) echo, WAIT is T+2 and `cmd_ready` returns T+3. Minimum issue rate: one command per 3 cycles.
- Rejected (overflow/underflow) commands take 1 cycle; the flag is visible T+1 and `cmd_ready` stays 1.
- `op_fire` is high only in the ISSUE cycle of an op.

Timeout:
- Echo absent: `err_timeout` is visible and IDLE is entered `ECHO_TIMEOUT` cycles after the first WAIT cycle.
- The wait counter clears on entering WAIT.

## Configuration
- `ACC_SEQ_ECHO_CHECK_EN`
  - Defined: WAIT state, echo compare and timeout as above.
  - Undefined:
    - ISSUE goes directly to IDLE and `accumulator_ctr` is ignored.
    - `err_timeout` is tied 0; `ECHO_TIMEOUT` is unused.
    - Minimum rate becomes one command per 2 cycles.

## Test plan
- **Three puts and an op:** puts 5, 9, 12 then op with `cmd_nargs`=3, echo model returns tag.
  - Tags 1, 2, 3, 4.
  - `value` 5, 9, 12 during the respective put strobes.
  - `fill_count` 1→2→3→0.
  - `op_fire` single pulse; no errors.
- **Overflow:** fourth put of 7 with `fill_count`=3 → `err_overflow`=1 at T+1, no `putEn`, `control_ctr` unchanged, `fill_count`=3; `err_clr` → flag 0.
- **Underflow:** one put, then op with `cmd_nargs`=2 → `err_underflow`=1, no `opEn`, `fill_count` stays 1.
- **Timeout:** echo held stale, `ECHO_TIMEOUT`=15 → `err_timeout` rises 15 cycles after the first WAIT cycle, FSM back to IDLE, strobes 0; the next put still issues with the incremented tag.
- **Tag wrap:** preload by issuing 4095 puts/ops → tag 4095 then 0; the echo of 0 is accepted.
- **Reset mid-WAIT:** `reset` in WAIT → next cycle all outputs at reset values, `cmd_ready`=1, `fill_count`=0.
